// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: sequencer state
// encoding, default parameters and the byte-lane merge used by writes and bypass.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_N_RD     = 2;
  localparam int DEF_ZERO_REG = 1;

  // One byte lane of a byte-enabled write: take the new byte when enabled.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: range / zero-register masking, same-cycle write
// bypass and the output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic [ADDR_W-1:0] src_add,
  input  logic [DATA_W-1:0] entry_data,
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [DATA_W-1:0] wr_merged,
  output logic [DATA_W-1:0] rd_data
);

  logic              addr_ok;
  logic [DATA_W-1:0] rd_n;

  assign addr_ok = (32'(src_add) < DEPTH) && !((ZERO_REG != 0) && (src_add == '0));

  // A write landing on this address in the same cycle wins over the stale entry.
  always_comb begin
    rd_n = '0;
    if (!busy && addr_ok) begin
      rd_n = (wr_ok && (wr_add == src_add)) ? wr_merged : entry_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_n;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: storage array, byte-enabled write path, N_RD
// registered read ports and the sequencer that sweeps the array to zero.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int N_RD     = DEF_N_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   write,
  input  logic [ADDR_W-1:0]      wr_data_add,
  input  logic [DATA_W-1:0]      wr_data_in,
  input  logic [DATA_W/8-1:0]    wr_be,
  input  logic                   clear,
  input  logic [N_RD*ADDR_W-1:0] src_add,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic                   busy,
  output state_t                 dbg_state
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic [DATA_W-1:0] wr_old, wr_merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  // Sweep visits every entry once; clear is only honoured from IDLE.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      ST_CLEAR: begin
        if (ptr == LAST_PTR) begin
          state_n = ST_IDLE;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_n = ST_CLEAR;
          ptr_n   = '0;
        end
      end
    endcase
  end

  assign busy      = (state == ST_CLEAR);
  assign dbg_state = state;

  assign wr_ok = (state == ST_IDLE) && write && (32'(wr_data_add) < DEPTH) &&
                 !((ZERO_REG != 0) && (wr_data_add == '0));

  assign wr_old = mem[wr_data_add];

  always_comb begin
    wr_merged = wr_old;
    for (int k = 0; k < BE_W; k++) begin
      wr_merged[8*k +: 8] = merge_byte(wr_old[8*k +: 8], wr_data_in[8*k +: 8], wr_be[k]);
    end
  end

  // Storage has no reset of its own; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[ptr] <= '0;
    else if (wr_ok)        mem[wr_data_add] <= wr_merged;
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] src_p;
    logic [DATA_W-1:0] entry_p;

    assign src_p   = src_add[p*ADDR_W +: ADDR_W];
    assign entry_p = mem[src_p];

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .busy      (busy),
      .src_add   (src_p),
      .entry_data(entry_p),
      .wr_ok     (wr_ok),
      .wr_add    (wr_data_add),
      .wr_merged (wr_merged),
      .rd_data   (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: a 32x32 two-port instance and a 20-entry
// three-port instance, both checked against an array-based reference model.
module tb_regfile_multiport;
  import regfile_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na, rst_nb;

  // instance A: defaults (DEPTH=32, N_RD=2)
  logic        a_write, a_clear, a_busy;
  logic [4:0]  a_wadd;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic [9:0]  a_src;
  logic [63:0] a_rd;
  state_t      a_state;

  // instance B: DEPTH=20, N_RD=3
  logic        b_write, b_clear, b_busy;
  logic [4:0]  b_wadd;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;
  logic [14:0] b_src;
  logic [95:0] b_rd;
  state_t      b_state;

  regfile_multiport u_dut_a (
    .clk(clk), .rst_n(rst_na), .write(a_write), .wr_data_add(a_wadd),
    .wr_data_in(a_wdata), .wr_be(a_be), .clear(a_clear), .src_add(a_src),
    .rd_data(a_rd), .busy(a_busy), .dbg_state(a_state)
  );

  regfile_multiport #(.DEPTH(20), .N_RD(3)) u_dut_b (
    .clk(clk), .rst_n(rst_nb), .write(b_write), .wr_data_add(b_wadd),
    .wr_data_in(b_wdata), .wr_be(b_be), .clear(b_clear), .src_add(b_src),
    .rd_data(b_rd), .busy(b_busy), .dbg_state(b_state)
  );

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mdl [2][32];
  int          sweep_left [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int depth_of(input int d);
    return (d == 0) ? 32 : 20;
  endfunction

  // Reset (or any clear) leaves the array all-zero once the sweep is done,
  // and reads return 0 during the sweep, so zero the model up front.
  task automatic model_reset(input int d);
    for (int i = 0; i < 32; i++) mdl[d][i] = '0;
    sweep_left[d] = depth_of(d);
  endtask

  // One clock of the reference: expected read data for up to three ports
  // and expected busy after the edge.
  task automatic model_cycle(input int d, input logic wr, input logic [4:0] wadd,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input logic clr, input logic [14:0] src,
                             output logic [95:0] exp, output logic exp_busy);
    int          depth;
    logic        wv;
    logic [31:0] merged;
    logic [4:0]  a;
    depth = depth_of(d);
    exp   = '0;
    if (sweep_left[d] > 0) begin
      sweep_left[d]--;
    end else begin
      wv     = wr && (int'(wadd) < depth) && (wadd != 5'd0);
      merged = mdl[d][wadd];
      for (int k = 0; k < 4; k++) if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
      for (int p = 0; p < 3; p++) begin
        a = src[5*p +: 5];
        if (a == 5'd0 || int'(a) >= depth) exp[32*p +: 32] = '0;
        else if (wv && wadd == a)          exp[32*p +: 32] = merged;
        else                               exp[32*p +: 32] = mdl[d][a];
      end
      if (wv) mdl[d][wadd] = merged;
      if (clr) model_reset(d);
    end
    exp_busy = (sweep_left[d] > 0);
  endtask

  // driver tasks: entered just after a falling edge, leave at the next one
  task automatic cycle_a(input logic wr, input logic [4:0] wadd, input logic [31:0] wdata,
                         input logic [3:0] be, input logic clr,
                         input logic [4:0] s0, input logic [4:0] s1);
    logic [95:0] e;
    logic        eb;
    a_write = wr; a_wadd = wadd; a_wdata = wdata; a_be = be; a_clear = clr;
    a_src   = {s1, s0};
    model_cycle(0, wr, wadd, wdata, be, clr, {5'd0, s1, s0}, e, eb);
    @(posedge clk); #1;
    check("a_rd0", a_rd[31:0], e[31:0]);
    check("a_rd1", a_rd[63:32], e[63:32]);
    check("a_busy", 32'(a_busy), 32'(eb));
    @(negedge clk);
  endtask

  task automatic idle_a(input logic [4:0] s0, input logic [4:0] s1);
    cycle_a(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, s0, s1);
  endtask

  task automatic cycle_b(input logic wr, input logic [4:0] wadd, input logic [31:0] wdata,
                         input logic [3:0] be, input logic clr,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2);
    logic [95:0] e;
    logic        eb;
    b_write = wr; b_wadd = wadd; b_wdata = wdata; b_be = be; b_clear = clr;
    b_src   = {s2, s1, s0};
    model_cycle(1, wr, wadd, wdata, be, clr, {s2, s1, s0}, e, eb);
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++) check($sformatf("b_rd%0d", p), b_rd[32*p +: 32], e[32*p +: 32]);
    check("b_busy", 32'(b_busy), 32'(eb));
    @(negedge clk);
  endtask

  task automatic reset_a(input int hold);
    rst_na = 1'b0;
    #1;
    check("a_rst_rd0", a_rd[31:0], 32'd0);
    check("a_rst_rd1", a_rd[63:32], 32'd0);
    check("a_rst_busy", 32'(a_busy), 32'd1);
    check("a_rst_state", 32'(a_state), 32'(ST_CLEAR));
    model_reset(0);
    repeat (hold) @(negedge clk);
    rst_na = 1'b1;
  endtask

  initial begin
    rst_na = 1'b0; rst_nb = 1'b0;
    a_write = 0; a_wadd = 0; a_wdata = 0; a_be = 0; a_clear = 0; a_src = 0;
    b_write = 0; b_wadd = 0; b_wdata = 0; b_be = 0; b_clear = 0; b_src = 0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    reset_a(2);

    // power-up sweep: writes attempted while busy must be dropped
    for (int i = 0; i < 32; i++)
      cycle_a(1'b1, 5'(i), $urandom, 4'hf, 1'b0, 5'(i), 5'(31 - i));
    for (int i = 0; i < 32; i++) idle_a(5'(i), 5'((i + 7) % 32));

    // fill every entry, then read back on both ports independently
    for (int i = 0; i < 32; i++)
      cycle_a(1'b1, 5'(i), $urandom, 4'hf, 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    for (int i = 0; i < 32; i++) idle_a(5'(i), 5'(31 - i));

    // partial byte-enable write
    cycle_a(1'b1, 5'd5, 32'h11223344, 4'hf, 1'b0, 5'd0, 5'd0);
    cycle_a(1'b1, 5'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0, 5'd0);
    idle_a(5'd5, 5'd5);
    check("merge_const", a_rd[31:0], 32'h11BB33DD);

    // same-cycle write and read of the same entry on both ports
    cycle_a(1'b1, 5'd7, 32'hDEADBEEF, 4'hf, 1'b0, 5'd7, 5'd7);
    check("bypass_p0", a_rd[31:0], 32'hDEADBEEF);
    check("bypass_p1", a_rd[63:32], 32'hDEADBEEF);

    // random traffic with occasional clear requests
    for (int i = 0; i < 400; i++)
      cycle_a(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 39) == 0),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    for (int i = 0; i < 40; i++) idle_a(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    // asynchronous reset while read data is non-zero
    cycle_a(1'b1, 5'd9, 32'h5A5A0001, 4'hf, 1'b0, 5'd9, 5'd9);
    check("pre_reset_rd", a_rd[31:0], 32'h5A5A0001);
    reset_a(3);

    // reset at sweep step 10, then the full sweep must repeat
    for (int i = 0; i < 10; i++) idle_a(5'(i), 5'(i));
    reset_a(2);
    for (int i = 0; i < 34; i++) idle_a(5'(i % 32), 5'(9));

    // instance B: sweep, out-of-range access, three ports, clear pulse
    rst_nb = 1'b1;
    for (int i = 0; i < 20; i++) cycle_b(1'b1, 5'(i), $urandom, 4'hf, 1'b0, 5'(i), 5'd25, 5'd3);
    cycle_b(1'b1, 5'd25, 32'hCAFE0001, 4'hf, 1'b0, 5'd25, 5'd25, 5'd25);
    check("b_oor_const", b_rd[31:0], 32'd0);
    for (int i = 0; i < 20; i++)
      cycle_b(1'b1, 5'(i), $urandom, 4'hf, 1'b0, 5'($urandom_range(0, 31)), 5'(i), 5'(19 - i));
    for (int i = 0; i < 26; i++) cycle_b(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'(i), 5'((i + 3) % 26), 5'(25 - i));
    cycle_b(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd4, 5'd4, 5'd4);
    for (int i = 0; i < 20; i++) cycle_b(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'(i), 5'(i), 5'(i));
    for (int i = 0; i < 20; i++) cycle_b(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'(i), 5'(19 - i), 5'(i));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
